// File: rtl/apx_mac_pkg.sv
// Shared types and saturation bounds for the approximate-multiplier MAC accumulator.
package apx_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bounds are returned at 64 bits so callers can compare against a wide
    // unclamped sum. This holds for any accumulator width up to 62 bits.
    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/apx_sat_add.sv
// Combinational signed saturating adder. It clamps acc_i + add_i to the ACC_WIDTH range
// and flags when clamping occurred.
module apx_sat_add
    import apx_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int ADD_WIDTH = 17
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic signed [ADD_WIDTH-1:0] add_i,
    output logic signed [ACC_WIDTH-1:0] sum_o,
    output logic                        ovf_o
);

    localparam logic signed [63:0] MAX_V = acc_max(ACC_WIDTH);
    localparam logic signed [63:0] MIN_V = acc_min(ACC_WIDTH);

    logic signed [63:0] sum_full;

    // NOTE: every output gets a default before the if-chain, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        sum_full = 64'(acc_i) + 64'(add_i);
        sum_o    = ACC_WIDTH'(sum_full);
        ovf_o    = 1'b0;
        if (sum_full > MAX_V) begin
            sum_o = ACC_WIDTH'(MAX_V);
            ovf_o = 1'b1;
        end else if (sum_full < MIN_V) begin
            sum_o = ACC_WIDTH'(MIN_V);
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/apx_mac_accum.sv
// Saturating MAC accumulator behind the approximate Booth multiplier, with valid/ready in and out.
// Optional per-product bias compensation is enabled by defining APX_ERR_COMP_EN.
module apx_mac_accum
    import apx_mac_pkg::*;
#(
    parameter int                        WIDTH     = 8,
    parameter int                        ACC_WIDTH = 24,
    parameter int                        CNT_WIDTH = 8,
    parameter logic signed [2*WIDTH-1:0] BIAS      = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    localparam int ADD_W = 2 * WIDTH + 1;

    state_e                 state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [ADD_W-1:0]     addend;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        ovf;
    logic                        beat_acc;

`ifdef APX_ERR_COMP_EN
    assign addend = ADD_W'($signed(in_prod)) + ADD_W'(BIAS);
`else
    logic unused_bias;
    assign unused_bias = ^BIAS;
    assign addend      = ADD_W'($signed(in_prod));
`endif

    apx_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .ADD_WIDTH (ADD_W)
    ) u_sat_add (
        .acc_i (acc_q),
        .add_i (addend),
        .sum_o (sum),
        .ovf_o (ovf)
    );

    assign beat_acc = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (beat_acc) begin
                    acc_d   = sum;
                    sat_d   = sat_q | ovf;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered from the next state. This keeps in_ready low during reset.
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_apx_mac_accum.sv
// Self-checking bench for apx_mac_accum: directed vector table, hand corner sequences, and a random
// stream checked against an arithmetic reference model.
module tb_apx_mac_accum;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int CNT_WIDTH = 4;
    localparam int PW        = 2 * WIDTH;
    localparam longint AMAX  = (64'sd1 <<< (ACC_WIDTH - 1)) - 1;
    localparam longint AMIN  = -(64'sd1 <<< (ACC_WIDTH - 1));
    localparam longint CMAX  = (64'sd1 <<< CNT_WIDTH) - 1;
`ifdef APX_ERR_COMP_EN
    localparam int B = 3;
`else
    localparam int B = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [PW-1:0]        in_prod;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_sat;

    int n_tests = 0;
    int n_fail  = 0;

    apx_mac_accum #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .BIAS      (16'sd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int     n;
        int     p[4];
        longint exp_acc;
        longint exp_cnt;
        bit     exp_sat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint acc_now();
        return longint'($signed(out_acc));
    endfunction

    // Reference model: clamp after every beat, sticky flag, count saturates at all-ones
    function automatic void model(input int prods[$], output longint acc,
                                  output longint cnt, output bit sat);
        acc = 0;
        sat = 1'b0;
        foreach (prods[i]) begin
            acc = acc + prods[i] + B;
            if (acc > AMAX) begin acc = AMAX; sat = 1'b1; end
            else if (acc < AMIN) begin acc = AMIN; sat = 1'b1; end
        end
        cnt = (prods.size() < CMAX) ? prods.size() : CMAX;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input int p, input bit last, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) begin
            in_prod = PW'($urandom);
            in_last = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_prod  = PW'(p);
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_vec(input string name, input int prods[$], input longint ea,
                           input longint ec, input bit es, input int gap_max, input int hold);
        int guard;
        for (int i = 0; i < prods.size(); i++)
            send(prods[i], i == prods.size() - 1, $urandom_range(0, gap_max));
        check({name, "_latency"}, longint'(out_valid), 1);
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_acc"}, acc_now(), ea);
        check({name, "_cnt"}, longint'(out_count), ec);
        check({name, "_sat"}, longint'(out_sat), longint'(es));
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_clr_valid"}, longint'(out_valid), 0);
        check({name, "_clr_ready"}, longint'(in_ready), 1);
        check({name, "_clr_acc"}, acc_now(), 0);
        check({name, "_clr_cnt"}, longint'(out_count), 0);
    endtask

    task automatic set_vec(input int i, input int n, input int p0, input int p1, input int p2,
                           input int p3, input longint ea, input longint ec, input bit es);
        vecs[i].n       = n;
        vecs[i].p[0]    = p0;
        vecs[i].p[1]    = p1;
        vecs[i].p[2]    = p2;
        vecs[i].p[3]    = p3;
        vecs[i].exp_acc = ea;
        vecs[i].exp_cnt = ec;
        vecs[i].exp_sat = es;
    endtask

    initial begin
        int     q[$];
        longint ea, ec, held_acc;
        bit     es;

        set_vec(0, 1, 9052, 0, 0, 0, 9052 + B, 1, 1'b0);
        set_vec(1, 3, 9052, -1000, 48, 0, 8100 + 3 * B, 3, 1'b0);
        set_vec(2, 2, 16384, 16384, 0, 0, 32767, 2, 1'b1);
        set_vec(3, 3, -16384, -16384, -16384, 0, -32768, 3, 1'b1);
        set_vec(4, 1, 32767, 0, 0, 0, 32767, 1, B > 0);
        set_vec(5, 1, -32768, 0, 0, 0, -32768 + B, 1, 1'b0);
        set_vec(6, 3, 32767, 100, -200, 0, 32567 + B, 3, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset held with in_valid asserted
        repeat (3) @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_in_ready", longint'(in_ready), 1);
        check("post_rst_acc", acc_now(), 0);
        check("post_rst_valid", longint'(out_valid), 0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            q.delete();
            for (int j = 0; j < vecs[i].n; j++) q.push_back(vecs[i].p[j]);
            run_vec($sformatf("vec%0d", i), q, vecs[i].exp_acc, vecs[i].exp_cnt,
                    vecs[i].exp_sat, 0, 0);
        end

        // Count saturates without touching the sat flag
        q.delete();
        repeat (17) q.push_back(1);
        run_vec("cnt_sat", q, 17 + 17 * B, 15, 1'b0, 1, 0);

        // Backpressure: hold the result while the producer keeps offering beats
        send(9052, 1'b0, 0);
        send(-1000, 1'b0, 0);
        send(48, 1'b1, 0);
        held_acc = 8100 + 3 * B;
        in_valid = 1'b1;
        in_prod  = PW'(5);
        in_last  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp%0d_valid", c), longint'(out_valid), 1);
            check($sformatf("bp%0d_ready", c), longint'(in_ready), 0);
            check($sformatf("bp%0d_acc", c), acc_now(), held_acc);
            check($sformatf("bp%0d_cnt", c), longint'(out_count), 3);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        check("bp_final_acc", acc_now(), held_acc);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", longint'(out_valid), 0);
        check("bp_release_ready", longint'(in_ready), 1);

        // Reset in the middle of a vector discards the partial sum
        send(100, 1'b0, 0);
        send(200, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midvec_rst_valid", longint'(out_valid), 0);
        check("midvec_rst_acc", acc_now(), 0);
        check("midvec_rst_cnt", longint'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q.delete();
        q.push_back(7);
        run_vec("after_rst", q, 7 + B, 1, 1'b0, 0, 0);

        // Reset while holding a result in DONE
        send(50, 1'b1, 0);
        check("middone_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("middone_rst_valid", longint'(out_valid), 0);
        check("middone_rst_acc", acc_now(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random vectors against the reference model
        for (int v = 0; v < 40; v++) begin
            q.delete();
            for (int k = 0; k < $urandom_range(1, 20); k++) begin
                if ($urandom_range(0, 1) == 1) q.push_back(int'($urandom_range(0, 65535)) - 32768);
                else q.push_back(int'($urandom_range(0, 4000)) - 2000);
            end
            model(q, ea, ec, es);
            run_vec($sformatf("rnd%0d", v), q, ea, ec, es, 2, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
